obi_icache_bridge: RTL and testbench

Parametrised successor to the single-beat core-instruction/I$ converter. It sits between the core instruction fetch port (OBI) and the tile instruction cache. It decouples grant from response: the cache response is registered, so `rvalid` always follows `gnt` by at least one cycle. It supports up to `MAX_OUTSTANDING` in-flight fetches with core back-pressure, a selectable cacheability policy, local alignment-error responses and a stall counter.

---
 rtl/redmule_tile_pkg.sv | 23 ++
 rtl/fifo_v3.sv | 74 +++++++
 rtl/obi_icache_bridge.sv | 110 +++++++++++
 tb/tb_obi_icache_bridge.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_tile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : redmule_tile_pkg                                             |
// | Description : Shared tile types: I$ cacheability policy, response entry.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package redmule_tile_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    CACHE_ALL     = 2'd0,
    CACHE_MEMTYPE = 2'd1,
    CACHE_RANGE   = 2'd2
  } icache_cacheable_mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } icache_rsp_t;

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_v3                                                      |
// | Description : In-order FIFO with optional fall-through, async low reset.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned CNT_W = ADDR_DEPTH + 1;

  logic [ADDR_DEPTH-1:0] r_rd_ptr;
  logic [ADDR_DEPTH-1:0] r_wr_ptr;
  logic [CNT_W-1:0]      r_cnt;
  dtype                  r_mem [2**ADDR_DEPTH];
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;

  // Fall-through: an empty FIFO hands the incoming word straight to the reader.
  assign w_bypass = FALL_THROUGH && (r_cnt == '0) && push_i;
  assign full_o   = (r_cnt == CNT_W'(DEPTH));
  assign empty_o  = (r_cnt == '0) && !w_bypass;
  assign w_push   = push_i && !full_o && !(w_bypass && pop_i);
  assign w_pop    = pop_i && (r_cnt != '0);
  assign data_o   = w_bypass ? data_i : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_icache_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : obi_icache_bridge                                            |
// | Description : OBI instruction fetch to tile I$ bridge, registered response.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module obi_icache_bridge
  import redmule_tile_pkg::*;
#(
  parameter int unsigned            ADDR_W          = 32,
  parameter int unsigned            DATA_W          = 32,
  parameter int unsigned            MAX_OUTSTANDING = 2,
  parameter icache_cacheable_mode_e CACHEABLE_MODE  = CACHE_ALL,
  parameter logic [ADDR_W-1:0]      CACHEABLE_BASE  = '0,
  parameter logic [ADDR_W-1:0]      CACHEABLE_END   = '1,
  parameter int unsigned            STALL_CNT_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   core_req_i,
  input  logic [ADDR_W-1:0]      core_addr_i,
  input  logic [1:0]             core_memtype_i,
  output logic                   core_gnt_o,
  output logic                   core_rvalid_o,
  input  logic                   core_rready_i,
  output logic [DATA_W-1:0]      core_rdata_o,
  output logic                   core_err_o,
  output logic                   cache_valid_o,
  output logic [ADDR_W-1:0]      cache_addr_o,
  output logic                   cache_cacheable_o,
  input  logic                   cache_ready_i,
  input  logic [DATA_W-1:0]      cache_data_i,
  input  logic                   cache_error_i,
  input  logic                   stall_clr_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned OFFSET_W = $clog2(DATA_W / 8);
  localparam int unsigned ENTRY_W  = DATA_W + 1;

  logic                   w_aligned;
  logic                   w_space;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_rst_n;
  logic [ENTRY_W-1:0]     w_push_entry;
  logic [ENTRY_W-1:0]     w_head;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Space is judged on registered occupancy only, so a same-cycle pop never
  // opens a grant and rready has no combinational path to gnt.
  assign w_aligned     = (core_addr_i[OFFSET_W-1:0] == '0);
  assign w_space       = !w_full;
  assign cache_valid_o = core_req_i & w_space & w_aligned;
  assign cache_addr_o  = core_addr_i;
  assign core_gnt_o    = core_req_i & w_space & (cache_ready_i | !w_aligned);

  // Misaligned fetches never reach the cache and answer locally with an error.
  assign w_push_entry = w_aligned ? {cache_data_i, cache_error_i}
                                  : {{DATA_W{1'b0}}, 1'b1};

  assign core_rvalid_o = !w_empty;
  assign w_pop         = core_rvalid_o & core_rready_i;
  assign core_rdata_o  = core_rvalid_o ? w_head[DATA_W:1] : '0;
  assign core_err_o    = core_rvalid_o & w_head[0];
  assign w_rst_n       = !rst_i;

  generate
    if (CACHEABLE_MODE == CACHE_MEMTYPE) begin : g_memtype
      assign cache_cacheable_o = core_memtype_i[1];
    end else if (CACHEABLE_MODE == CACHE_RANGE) begin : g_range
      assign cache_cacheable_o = (core_addr_i >= CACHEABLE_BASE) &&
                                 (core_addr_i <= CACHEABLE_END);
    end else begin : g_all
      assign cache_cacheable_o = 1'b1;
    end
  endgenerate

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (ENTRY_W),
    .DEPTH        (MAX_OUTSTANDING),
    .dtype        (logic [ENTRY_W-1:0])
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (w_rst_n),
    .flush_i (1'b0),
    .full_o  (w_full),
    .empty_o (w_empty),
    .data_i  (w_push_entry),
    .push_i  (core_gnt_o),
    .data_o  (w_head),
    .pop_i   (w_pop)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (stall_clr_i) begin
      r_stall_cnt <= '0;
    end else if (core_req_i && !core_gnt_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_obi_icache_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_obi_icache_bridge                                         |
// | Description : Self-checking bench for obi_icache_bridge.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_obi_icache_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // main instance: depth 2, address-range cacheability 0x1000..0x1FFF
  logic        req = 0, rready = 0, cready = 0, cerr = 0, clr = 0;
  logic [31:0] addr = 0, cdata = 0;
  logic [1:0]  memtype = 0;
  logic        gnt, rvalid, err, cvalid, cacheable;
  logic [31:0] rdata, caddr;
  logic [15:0] stall_cnt;

  // shared stimulus for the depth-1/memtype and default instances
  logic        b_req = 0, b_rready = 0, b_cready = 0;
  logic [31:0] b_addr = 0, b_cdata = 0;
  logic [1:0]  b_memtype = 0;
  logic        b1_gnt, b1_rvalid, b1_err, b1_cvalid, b1_cacheable;
  logic [31:0] b1_rdata, b1_caddr;
  logic [15:0] b1_stall;
  logic        b2_gnt, b2_rvalid, b2_err, b2_cvalid, b2_cacheable;
  logic [31:0] b2_rdata, b2_caddr;
  logic [15:0] b2_stall;

  int n_checks = 0;
  int n_fail   = 0;

  obi_icache_bridge #(
    .MAX_OUTSTANDING (2),
    .CACHEABLE_MODE  (redmule_tile_pkg::CACHE_RANGE),
    .CACHEABLE_BASE  (32'h0000_1000),
    .CACHEABLE_END   (32'h0000_1FFF)
  ) u_dut (
    .clk_i (clk), .rst_i (rst), .core_req_i (req), .core_addr_i (addr),
    .core_memtype_i (memtype), .core_gnt_o (gnt), .core_rvalid_o (rvalid),
    .core_rready_i (rready), .core_rdata_o (rdata), .core_err_o (err),
    .cache_valid_o (cvalid), .cache_addr_o (caddr), .cache_cacheable_o (cacheable),
    .cache_ready_i (cready), .cache_data_i (cdata), .cache_error_i (cerr),
    .stall_clr_i (clr), .stall_cnt_o (stall_cnt)
  );

  obi_icache_bridge #(
    .MAX_OUTSTANDING (1),
    .CACHEABLE_MODE  (redmule_tile_pkg::CACHE_MEMTYPE)
  ) u_dut1 (
    .clk_i (clk), .rst_i (rst), .core_req_i (b_req), .core_addr_i (b_addr),
    .core_memtype_i (b_memtype), .core_gnt_o (b1_gnt), .core_rvalid_o (b1_rvalid),
    .core_rready_i (b_rready), .core_rdata_o (b1_rdata), .core_err_o (b1_err),
    .cache_valid_o (b1_cvalid), .cache_addr_o (b1_caddr), .cache_cacheable_o (b1_cacheable),
    .cache_ready_i (b_cready), .cache_data_i (b_cdata), .cache_error_i (1'b0),
    .stall_clr_i (1'b0), .stall_cnt_o (b1_stall)
  );

  obi_icache_bridge u_dut2 (
    .clk_i (clk), .rst_i (rst), .core_req_i (b_req), .core_addr_i (b_addr),
    .core_memtype_i (b_memtype), .core_gnt_o (b2_gnt), .core_rvalid_o (b2_rvalid),
    .core_rready_i (b_rready), .core_rdata_o (b2_rdata), .core_err_o (b2_err),
    .cache_valid_o (b2_cvalid), .cache_addr_o (b2_caddr), .cache_cacheable_o (b2_cacheable),
    .cache_ready_i (b_cready), .cache_data_i (b_cdata), .cache_error_i (1'b0),
    .stall_clr_i (1'b0), .stall_cnt_o (b2_stall)
  );

  function automatic logic [31:0] d_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %h expected 0", stall_cnt); end
    n_checks++; if ({gnt, cvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_cvalid: got %b expected 00", {gnt, cvalid}); end
    @(posedge clk);
    #1 rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_fetch();
    req = 1; addr = 32'h1000; cready = 1; cdata = 32'hDEAD_BEEF; cerr = 0; rready = 1;
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b expected 1", gnt); end
    n_checks++; if (cvalid !== 1'b1) begin n_fail++; $display("FAIL single_cvalid: got %b expected 1", cvalid); end
    n_checks++; if (caddr !== 32'h1000) begin n_fail++; $display("FAIL single_caddr: got %h expected 1000", caddr); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_T: got %b expected 0", rvalid); end
    next_cycle();
    req = 0; cready = 0; cdata = 0;
    #1;
    n_checks++; if ({rvalid, err} !== 2'b10) begin n_fail++; $display("FAIL single_rvalid_T1: got %b expected 10", {rvalid, err}); end
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", rdata); end
    next_cycle();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_T2: got %b expected 0", rvalid); end
  endtask

  task automatic test_back_pressure();
    rready = 0; cready = 1; cerr = 0; req = 1; clr = 1;
    addr = 32'h1100; cdata = d_of(addr);
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL bp_gnt0: got %b expected 1", gnt); end
    next_cycle();
    clr = 0; addr = 32'h1104; cdata = d_of(addr);
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL bp_gnt1: got %b expected 1", gnt); end
    next_cycle();
    addr = 32'h1108; cdata = d_of(addr);
    #1;
    n_checks++; if ({gnt, cvalid} !== 2'b00) begin n_fail++; $display("FAIL bp_full_block: got %b expected 00", {gnt, cvalid}); end
    next_cycle();
    rready = 1;
    #1;
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_stall1: got %0d expected 1", stall_cnt); end
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL bp_no_gnt_on_pop: got %b expected 0", gnt); end
    n_checks++; if (rdata !== d_of(32'h1100)) begin n_fail++; $display("FAIL bp_rdata0: got %h expected %h", rdata, d_of(32'h1100)); end
    next_cycle();
    #1;
    n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_stall2: got %0d expected 2", stall_cnt); end
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL bp_gnt2: got %b expected 1", gnt); end
    n_checks++; if (rdata !== d_of(32'h1104)) begin n_fail++; $display("FAIL bp_rdata1: got %h expected %h", rdata, d_of(32'h1104)); end
    next_cycle();
    req = 0; cready = 0;
    #1;
    n_checks++; if ({rvalid, rdata} !== {1'b1, d_of(32'h1108)}) begin n_fail++; $display("FAIL bp_rdata2: got %b/%h expected 1/%h", rvalid, rdata, d_of(32'h1108)); end
    next_cycle();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", rvalid); end
  endtask

  task automatic test_unaligned();
    req = 1; addr = 32'h1002; cready = 0; rready = 1;
    #1;
    n_checks++; if ({gnt, cvalid} !== 2'b10) begin n_fail++; $display("FAIL unal_gnt_cvalid: got %b expected 10", {gnt, cvalid}); end
    next_cycle();
    req = 0;
    #1;
    n_checks++; if ({rvalid, err, rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL unal_rsp: got %b%b/%h expected 11/0", rvalid, err, rdata); end
    next_cycle();
  endtask

  task automatic test_cache_range();
    logic [31:0] a [4];
    logic        e [4];
    a[0] = 32'h0FFC; a[1] = 32'h1000; a[2] = 32'h1FFC; a[3] = 32'h2000;
    e[0] = 0; e[1] = 1; e[2] = 1; e[3] = 0;
    req = 0;
    for (int i = 0; i < 4; i++) begin
      addr = a[i];
      #1;
      n_checks++; if (cacheable !== e[i]) begin n_fail++; $display("FAIL range_%h: got %b expected %b", a[i], cacheable, e[i]); end
    end
  endtask

  task automatic test_cache_error();
    req = 1; addr = 32'h1200; cready = 1; cdata = 32'h1234_5678; cerr = 1; rready = 1;
    next_cycle();
    req = 0; cready = 0; cerr = 0;
    #1;
    n_checks++; if ({rvalid, err, rdata} !== {2'b11, 32'h1234_5678}) begin n_fail++; $display("FAIL cerr_rsp: got %b%b/%h expected 11/12345678", rvalid, err, rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    rready = 0; cready = 1; req = 1;
    addr = 32'h1300; cdata = d_of(addr); next_cycle();
    addr = 32'h1304; cdata = d_of(addr); next_cycle();
    req = 0; cready = 0;
    #1;
    n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 1", rvalid); end
    rst = 1;
    #1;
    n_checks++; if ({rvalid, rdata} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rstmid_flush: got %b/%h expected 0/0", rvalid, rdata); end
    next_cycle();
    rst = 0;
    next_cycle();
    rready = 1; req = 1; cready = 1; addr = 32'h1400; cdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 1", gnt); end
    next_cycle();
    req = 0; cready = 0;
    #1;
    n_checks++; if ({rvalid, rdata} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL rstmid_rsp: got %b/%h expected 1/cafef00d", rvalid, rdata); end
    next_cycle();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got %b expected 0", rvalid); end
  endtask

  task automatic test_stall_saturation();
    clr = 1; req = 0; next_cycle();
    clr = 0; req = 1; cready = 1; rready = 0; addr = 32'h1500; cdata = d_of(addr);
    repeat (65545) @(posedge clk);
    #2;
    n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat: got %h expected ffff", stall_cnt); end
    clr = 1;
    next_cycle();
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL stall_clr_prio: got %h expected 0", stall_cnt); end
    clr = 0;
    next_cycle();
    n_checks++; if (stall_cnt !== 16'h1) begin n_fail++; $display("FAIL stall_after_clr: got %h expected 1", stall_cnt); end
    req = 0; cready = 0; rready = 1;
    repeat (3) next_cycle();
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    int          stall_m;
    logic        al, sp, e_gnt, e_cv, e_ca, e_rv, e_er;
    logic [31:0] e_rd;
    clr = 1; req = 0; rready = 1; next_cycle();
    clr = 0;
    stall_m = 0;
    for (int i = 0; i < 400; i++) begin
      req    = ($urandom_range(9) < 7);
      addr   = 32'h0F00 + ($urandom_range(1200) * 4);
      if ($urandom_range(7) == 0) addr = addr + $urandom_range(1, 3);
      cready = $urandom_range(1);
      cdata  = $urandom;
      cerr   = ($urandom_range(7) == 0);
      rready = ($urandom_range(9) < 6);
      clr    = ($urandom_range(31) == 0);
      #1;
      al    = (addr % 4 == 0);
      sp    = (q.size() < 2);
      e_gnt = req && sp && (cready || !al);
      e_cv  = req && sp && al;
      e_ca  = (addr >= 32'h1000) && (addr <= 32'h1FFF);
      e_rv  = (q.size() != 0);
      e_rd  = e_rv ? q[0][32:1] : 32'h0;
      e_er  = e_rv ? q[0][0] : 1'b0;
      n_checks++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b expected %b", i, gnt, e_gnt); end
      n_checks++; if (cvalid !== e_cv) begin n_fail++; $display("FAIL rnd_cvalid@%0d: got %b expected %b", i, cvalid, e_cv); end
      n_checks++; if (cacheable !== e_ca) begin n_fail++; $display("FAIL rnd_cacheable@%0d: got %b expected %b", i, cacheable, e_ca); end
      n_checks++; if ({rvalid, err, rdata} !== {e_rv, e_er, e_rd}) begin n_fail++; $display("FAIL rnd_rsp@%0d: got %b%b/%h expected %b%b/%h", i, rvalid, err, rdata, e_rv, e_er, e_rd); end
      n_checks++; if (stall_cnt !== 16'(stall_m)) begin n_fail++; $display("FAIL rnd_stall@%0d: got %0d expected %0d", i, stall_cnt, stall_m); end
      if (e_rv && rready) void'(q.pop_front());
      if (e_gnt) q.push_back(al ? {cdata, cerr} : {32'h0, 1'b1});
      if (clr) stall_m = 0;
      else if (req && !e_gnt && stall_m < 65535) stall_m++;
      next_cycle();
    end
    req = 0; clr = 0; cready = 0; cerr = 0; rready = 1;
    repeat (3) next_cycle();
  endtask

  task automatic test_depth_throughput();
    logic [31:0] prev1, prev2;
    b_req = 1; b_addr = 32'h2000; b_memtype = 2'b10; b_cready = 1; b_rready = 1;
    prev1 = 0; prev2 = 0;
    for (int i = 0; i < 8; i++) begin
      b_cdata = $urandom;
      #1;
      n_checks++; if (b1_gnt !== (i % 2 == 0)) begin n_fail++; $display("FAIL d1_gnt@%0d: got %b expected %b", i, b1_gnt, (i % 2 == 0)); end
      n_checks++; if (b1_rvalid !== (i % 2 == 1)) begin n_fail++; $display("FAIL d1_rvalid@%0d: got %b expected %b", i, b1_rvalid, (i % 2 == 1)); end
      if (i % 2 == 1) begin
        n_checks++; if (b1_rdata !== prev1) begin n_fail++; $display("FAIL d1_rdata@%0d: got %h expected %h", i, b1_rdata, prev1); end
      end
      n_checks++; if (b2_gnt !== 1'b1) begin n_fail++; $display("FAIL d2_gnt@%0d: got %b expected 1", i, b2_gnt); end
      if (i > 0) begin
        n_checks++; if ({b2_rvalid, b2_rdata} !== {1'b1, prev2}) begin n_fail++; $display("FAIL d2_rsp@%0d: got %b/%h expected 1/%h", i, b2_rvalid, b2_rdata, prev2); end
      end
      if (i % 2 == 0) prev1 = b_cdata;
      prev2 = b_cdata;
      next_cycle();
    end
    b_req = 0;
    #1;
    n_checks++; if ({b1_cacheable, b2_cacheable} !== 2'b11) begin n_fail++; $display("FAIL memtype_hi: got %b expected 11", {b1_cacheable, b2_cacheable}); end
    b_memtype = 2'b01;
    #1;
    n_checks++; if ({b1_cacheable, b2_cacheable} !== 2'b01) begin n_fail++; $display("FAIL memtype_lo: got %b expected 01", {b1_cacheable, b2_cacheable}); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_pressure();
    test_unaligned();
    test_cache_range();
    test_cache_error();
    test_reset_mid();
    test_stall_saturation();
    test_random();
    test_depth_throughput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
